// File: rtl/dm_reg_access_master_if.sv
// dm_reg_access_master_if
// Groups the abstract-command handshake, the response channel and the
// control half of the DM register access bus (strobe, direction, address).
// The shared 32-bit data net is a plain inout on the master itself so it
// resolves as an ordinary tristate net between the master and the responder.
interface dm_reg_access_master_if;
   // Command channel
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_write_i;
   logic [15:0] cmd_regno_i;
   logic [31:0] cmd_wdata_i;
   logic        hart_halted_i;
   // Response channel
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic [2:0]  rsp_cmderr_o;
   // Register access bus control
   logic        dm_reg_rd_wr_en_o;
   logic        dm_reg_rd_wr_o;
   logic [15:0] dm_reg_rd_wr_address_o;

   modport master (
      input  cmd_valid_i, cmd_write_i, cmd_regno_i, cmd_wdata_i, hart_halted_i,
      output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_cmderr_o,
      output dm_reg_rd_wr_en_o, dm_reg_rd_wr_o, dm_reg_rd_wr_address_o
   );

   modport slave (
      output cmd_valid_i, cmd_write_i, cmd_regno_i, cmd_wdata_i, hart_halted_i,
      input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_cmderr_o,
      input  dm_reg_rd_wr_en_o, dm_reg_rd_wr_o, dm_reg_rd_wr_address_o
   );
endinterface

// File: rtl/dm_reg_access_master.sv
// dm_reg_access_master
// Debug-module initiator on the DM register access bus. Accepts one abstract
// register command, checks halt state and register number, runs a single
// bus transaction and returns one response with read data and cmderr.
// Optional feature: define DM_REG_WRITE_VERIFY_EN to add a read-back (VREAD)
// after every write; a read-back differing from the write data gives cmderr 5.
// All bus and response outputs are registered from the next-state value, so
// they change exactly on the edge that enters the corresponding state.
module dm_reg_access_master #(
   parameter logic [15:0] GPR_BASE = 16'h1000,
   parameter logic [15:0] CSR_BASE = 16'h07B0
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   dm_reg_access_master_if.master bus_if,
   inout  wire  [31:0]            dm_reg_rd_wr_data_io
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_WRITE  = 3'd2;
   localparam logic [2:0] ST_READ   = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;
`ifdef DM_REG_WRITE_VERIFY_EN
   localparam logic [2:0] ST_VREAD  = 3'd5;
`endif

   localparam logic [2:0] ERR_OK      = 3'd0;
   localparam logic [2:0] ERR_NOTSUP  = 3'd2;
   localparam logic [2:0] ERR_HALT    = 3'd4;
`ifdef DM_REG_WRITE_VERIFY_EN
   localparam logic [2:0] ERR_VERIFY  = 3'd5;
`endif

   // Register number lies in the GPR window or the debug CSR window.
   function automatic logic regno_valid(input logic [15:0] regno);
      logic [15:0] gpr_off;
      logic [15:0] csr_off;
      gpr_off = regno - GPR_BASE;
      csr_off = regno - CSR_BASE;
      return ((regno >= GPR_BASE) && (gpr_off < 16'd32)) ||
             ((regno >= CSR_BASE) && (csr_off < 16'd4));
   endfunction

   logic [2:0]  r_state;
   logic        r_write;
   logic [15:0] r_regno;
   logic [31:0] r_wdata;
   logic        r_ready;
   logic        r_rsp_valid;
   logic [31:0] r_rdata;
   logic [2:0]  r_cmderr;
   logic        r_en;
   logic        r_rd_wr;
   logic [15:0] r_addr;
   logic        r_drive;

   logic [2:0]  w_next_state;
   logic [2:0]  w_cmderr_next;
   logic        w_accept;
   logic        w_regno_ok;
   logic        w_sample;
   logic        w_next_bus;

   assign w_accept   = bus_if.cmd_valid_i & r_ready;
   assign w_regno_ok = regno_valid(r_regno);

`ifdef DM_REG_WRITE_VERIFY_EN
   assign w_sample   = (r_state == ST_READ) || (r_state == ST_VREAD);
   assign w_next_bus = (w_next_state == ST_WRITE) || (w_next_state == ST_READ) ||
                       (w_next_state == ST_VREAD);
`else
   assign w_sample   = (r_state == ST_READ);
   assign w_next_bus = (w_next_state == ST_WRITE) || (w_next_state == ST_READ);
`endif

   // Master owns the shared data net only while the write strobe is up.
   assign dm_reg_rd_wr_data_io = r_drive ? r_wdata : 32'hzzzz_zzzz;

   assign bus_if.cmd_ready_o            = r_ready;
   assign bus_if.rsp_valid_o            = r_rsp_valid;
   assign bus_if.rsp_rdata_o            = r_rdata;
   assign bus_if.rsp_cmderr_o           = r_cmderr;
   assign bus_if.dm_reg_rd_wr_en_o      = r_en;
   assign bus_if.dm_reg_rd_wr_o         = r_rd_wr;
   assign bus_if.dm_reg_rd_wr_address_o = r_addr;

   // Next-state decode; the halt check outranks the register-number check.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_next_state = ST_DECODE;
            else          w_next_state = ST_IDLE;
         end
         ST_DECODE: begin
            if (!bus_if.hart_halted_i) w_next_state = ST_DONE;
            else if (!w_regno_ok)      w_next_state = ST_DONE;
            else if (r_write)          w_next_state = ST_WRITE;
            else                       w_next_state = ST_READ;
         end
`ifdef DM_REG_WRITE_VERIFY_EN
         ST_WRITE: w_next_state = ST_VREAD;
         ST_VREAD: w_next_state = ST_DONE;
`else
         ST_WRITE: w_next_state = ST_DONE;
`endif
         ST_READ:  w_next_state = ST_DONE;
         ST_DONE:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Error code: set in DECODE, and by the read-back compare when enabled.
   always_comb begin
      w_cmderr_next = r_cmderr;
      if (r_state == ST_DECODE) begin
         if (!bus_if.hart_halted_i) w_cmderr_next = ERR_HALT;
         else if (!w_regno_ok)      w_cmderr_next = ERR_NOTSUP;
         else                       w_cmderr_next = ERR_OK;
      end
`ifdef DM_REG_WRITE_VERIFY_EN
      else if (r_state == ST_VREAD) begin
         if (dm_reg_rd_wr_data_io != r_wdata) w_cmderr_next = ERR_VERIFY;
         else                                 w_cmderr_next = ERR_OK;
      end
`endif
      else begin
         w_cmderr_next = r_cmderr;
      end
   end

   // State register and registered handshake / bus control outputs.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state     <= ST_IDLE;
         r_ready     <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_en        <= 1'b0;
         r_rd_wr     <= 1'b0;
         r_addr      <= 16'h0000;
         r_drive     <= 1'b0;
         r_cmderr    <= 3'd0;
      end else begin
         r_state     <= w_next_state;
         r_ready     <= (w_next_state == ST_IDLE);
         r_rsp_valid <= (w_next_state == ST_DONE);
         r_en        <= w_next_bus;
         r_rd_wr     <= (w_next_state == ST_WRITE);
         r_addr      <= w_next_bus ? r_regno : 16'h0000;
         r_drive     <= (w_next_state == ST_WRITE);
         r_cmderr    <= w_cmderr_next;
      end
   end

   // Command latch; cmd_* inputs only matter on the accept edge.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_write <= 1'b0;
         r_regno <= 16'h0000;
         r_wdata <= 32'h0000_0000;
      end else if (w_accept) begin
         r_write <= bus_if.cmd_write_i;
         r_regno <= bus_if.cmd_regno_i;
         r_wdata <= bus_if.cmd_wdata_i;
      end else begin
         r_write <= r_write;
         r_regno <= r_regno;
         r_wdata <= r_wdata;
      end
   end

   // Read data captured on the edge closing a read cycle; held otherwise.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_rdata <= 32'h0000_0000;
      end else if (w_sample) begin
         r_rdata <= dm_reg_rd_wr_data_io;
      end else begin
         r_rdata <= r_rdata;
      end
   end

endmodule

// File: tb/tb_dm_reg_access_master.sv
// tb_dm_reg_access_master
// Directed bench for dm_reg_access_master with a combinational core-side
// responder on the shared data net. Define DM_REG_WRITE_VERIFY_EN to build
// the read-back variant and its extra directed case.
module tb_dm_reg_access_master;

   logic        clk_i;
   logic        reset_i;
   wire  [31:0] w_bus;
   logic [31:0] resp_data;
   logic [31:0] last_rdata;
   int          n_checks;
   int          n_errors;

   dm_reg_access_master_if u_if ();

   dm_reg_access_master dut (
      .clk_i                (clk_i),
      .reset_i              (reset_i),
      .bus_if               (u_if.master),
      .dm_reg_rd_wr_data_io (w_bus)
   );

   // Core responder drives read data combinationally during read strobes.
   wire resp_en = u_if.dm_reg_rd_wr_en_o & ~u_if.dm_reg_rd_wr_o;
   assign w_bus = resp_en ? resp_data : 32'hzzzz_zzzz;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic [15:0] bnd_regno [0:5] = '{16'h1000, 16'h101F, 16'h1020, 16'h07AF, 16'h07B3, 16'h07B4};
   logic [2:0]  bnd_err   [0:5] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd0, 3'd2};

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      n_checks = n_checks + 1;
      if (obs != expd) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expd, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic present(input logic w, input logic [15:0] regno, input logic [31:0] wdata);
      u_if.cmd_write_i = w;
      u_if.cmd_regno_i = regno;
      u_if.cmd_wdata_i = wdata;
      u_if.cmd_valid_i = 1'b1;
   endtask

   task automatic accept();
      step();
      u_if.cmd_valid_i = 1'b0;
   endtask

   task automatic dec_checks();
      check_val("dec_en",    {31'd0, u_if.dm_reg_rd_wr_en_o}, 32'd0);
      check_val("dec_ready", {31'd0, u_if.cmd_ready_o}, 32'd0);
      check_val("dec_drive", {31'd0, dut.r_drive}, 32'd0);
      check_val("dec_rspv",  {31'd0, u_if.rsp_valid_o}, 32'd0);
   endtask

   task automatic done_checks(input logic [2:0] exp_err);
      check_val("done_rspv",  {31'd0, u_if.rsp_valid_o}, 32'd1);
      check_val("done_err",   {29'd0, u_if.rsp_cmderr_o}, {29'd0, exp_err});
      check_val("done_en",    {31'd0, u_if.dm_reg_rd_wr_en_o}, 32'd0);
      check_val("done_rdwr",  {31'd0, u_if.dm_reg_rd_wr_o}, 32'd0);
      check_val("done_addr",  {16'd0, u_if.dm_reg_rd_wr_address_o}, 32'd0);
      check_val("done_drive", {31'd0, dut.r_drive}, 32'd0);
      check_val("done_ready", {31'd0, u_if.cmd_ready_o}, 32'd0);
      check_val("done_rdata", u_if.rsp_rdata_o, last_rdata);
   endtask

   // Starts in the DECODE cycle, ends in the DONE cycle.
   task automatic write_tail(input logic [15:0] regno, input logic [31:0] wdata, input logic [2:0] exp_err);
      dec_checks();
      step();
      check_val("wr_en",    {31'd0, u_if.dm_reg_rd_wr_en_o}, 32'd1);
      check_val("wr_rdwr",  {31'd0, u_if.dm_reg_rd_wr_o}, 32'd1);
      check_val("wr_addr",  {16'd0, u_if.dm_reg_rd_wr_address_o}, {16'd0, regno});
      check_val("wr_drive", {31'd0, dut.r_drive}, 32'd1);
      check_val("wr_bus",   w_bus, wdata);
      check_val("wr_rspv",  {31'd0, u_if.rsp_valid_o}, 32'd0);
`ifdef DM_REG_WRITE_VERIFY_EN
      step();
      check_val("vr_en",    {31'd0, u_if.dm_reg_rd_wr_en_o}, 32'd1);
      check_val("vr_rdwr",  {31'd0, u_if.dm_reg_rd_wr_o}, 32'd0);
      check_val("vr_addr",  {16'd0, u_if.dm_reg_rd_wr_address_o}, {16'd0, regno});
      check_val("vr_drive", {31'd0, dut.r_drive}, 32'd0);
      check_val("vr_rspv",  {31'd0, u_if.rsp_valid_o}, 32'd0);
      last_rdata = resp_data;
`endif
      step();
      done_checks(exp_err);
   endtask

   // Starts in the DECODE cycle, ends in the DONE cycle.
   task automatic read_tail(input logic [15:0] regno, input logic [2:0] exp_err, input logic [31:0] exp_data);
      dec_checks();
      step();
      if (exp_err == 3'd0) begin
         check_val("rd_en",    {31'd0, u_if.dm_reg_rd_wr_en_o}, 32'd1);
         check_val("rd_rdwr",  {31'd0, u_if.dm_reg_rd_wr_o}, 32'd0);
         check_val("rd_addr",  {16'd0, u_if.dm_reg_rd_wr_address_o}, {16'd0, regno});
         check_val("rd_drive", {31'd0, dut.r_drive}, 32'd0);
         check_val("rd_bus",   w_bus, exp_data);
         check_val("rd_rspv",  {31'd0, u_if.rsp_valid_o}, 32'd0);
         step();
         last_rdata = exp_data;
      end
      done_checks(exp_err);
   endtask

   task automatic finish_cmd();
      step();
      check_val("idle_ready", {31'd0, u_if.cmd_ready_o}, 32'd1);
      check_val("idle_rspv",  {31'd0, u_if.rsp_valid_o}, 32'd0);
   endtask

   // Master and responder must never drive the data net together.
   always @(negedge clk_i) begin
      check_val("contention", {31'd0, dut.r_drive & resp_en}, 32'd0);
   end

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      last_rdata = 32'h0;
      resp_data  = 32'h0;
      reset_i    = 1'b1;
      u_if.cmd_valid_i   = 1'b0;
      u_if.cmd_write_i   = 1'b0;
      u_if.cmd_regno_i   = 16'h0;
      u_if.cmd_wdata_i   = 32'h0;
      u_if.hart_halted_i = 1'b1;

      // Reset values
      #2;
      check_val("rst_ready", {31'd0, u_if.cmd_ready_o}, 32'd1);
      check_val("rst_rspv",  {31'd0, u_if.rsp_valid_o}, 32'd0);
      check_val("rst_rdata", u_if.rsp_rdata_o, 32'h0);
      check_val("rst_err",   {29'd0, u_if.rsp_cmderr_o}, 32'd0);
      check_val("rst_en",    {31'd0, u_if.dm_reg_rd_wr_en_o}, 32'd0);
      check_val("rst_rdwr",  {31'd0, u_if.dm_reg_rd_wr_o}, 32'd0);
      check_val("rst_addr",  {16'd0, u_if.dm_reg_rd_wr_address_o}, 32'd0);
      check_val("rst_drive", {31'd0, dut.r_drive}, 32'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      step();

      // Halted write to x5
      resp_data = 32'hDEAD_BEEF;
      present(1'b1, 16'h1005, 32'hDEAD_BEEF);
      accept();
      write_tail(16'h1005, 32'hDEAD_BEEF, 3'd0);
      finish_cmd();

      // Halted read of dscratch0
      resp_data = 32'h1234_5678;
      present(1'b0, 16'h07B2, 32'h0);
      accept();
      read_tail(16'h07B2, 3'd0, 32'h1234_5678);
      finish_cmd();

      // Unsupported regno: no strobe, rdata held
      resp_data = 32'hFFFF_FFFF;
      present(1'b0, 16'h0300, 32'h0);
      accept();
      read_tail(16'h0300, 3'd2, 32'h0);
      finish_cmd();

      // Hart not halted, valid and invalid regno (halt check wins)
      u_if.hart_halted_i = 1'b0;
      present(1'b0, 16'h1000, 32'h0);
      accept();
      read_tail(16'h1000, 3'd4, 32'h0);
      finish_cmd();
      present(1'b1, 16'h0300, 32'h1111_2222);
      accept();
      read_tail(16'h0300, 3'd4, 32'h0);
      finish_cmd();
      u_if.hart_halted_i = 1'b1;

      // Window boundaries
      for (int i = 0; i < 6; i++) begin
         resp_data = {16'hC0DE, bnd_regno[i]};
         present(1'b0, bnd_regno[i], 32'h0);
         accept();
         read_tail(bnd_regno[i], bnd_err[i], {16'hC0DE, bnd_regno[i]});
         finish_cmd();
      end

      // Reset asserted during the READ cycle
      resp_data = 32'h0BAD_F00D;
      present(1'b0, 16'h07B0, 32'h0);
      accept();
      step();
      check_val("rr_en_pre", {31'd0, u_if.dm_reg_rd_wr_en_o}, 32'd1);
      #2;
      reset_i = 1'b1;
      #1;
      check_val("rr_en",    {31'd0, u_if.dm_reg_rd_wr_en_o}, 32'd0);
      check_val("rr_drive", {31'd0, dut.r_drive}, 32'd0);
      check_val("rr_rspv",  {31'd0, u_if.rsp_valid_o}, 32'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      last_rdata = 32'h0;
      finish_cmd();
      check_val("rr_rdata", u_if.rsp_rdata_o, 32'h0);
      step();
      check_val("rr_norsp", {31'd0, u_if.rsp_valid_o}, 32'd0);

      // Back-to-back write then read of dpc with cmd_valid held high
      resp_data = 32'hA5A5_0F0F;
      present(1'b1, 16'h07B1, 32'hA5A5_0F0F);
      step();
      present(1'b0, 16'h07B1, 32'h0);
      write_tail(16'h07B1, 32'hA5A5_0F0F, 3'd0);
      step();
      check_val("b2b_ready", {31'd0, u_if.cmd_ready_o}, 32'd1);
      step();
      u_if.cmd_valid_i = 1'b0;
      read_tail(16'h07B1, 3'd0, 32'hA5A5_0F0F);
      finish_cmd();

`ifdef DM_REG_WRITE_VERIFY_EN
      // Read-back disagrees with the written value
      resp_data = 32'h0;
      present(1'b1, 16'h07B0, 32'h5);
      accept();
      write_tail(16'h07B0, 32'h5, 3'd5);
      finish_cmd();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
